// File: rtl/pw_pkg.sv
// Shared types and constants for the brute-force password datapath.
package pw_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEARCH    = 2'd1,
    FOUND     = 2'd2,
    EXHAUSTED = 2'd3
  } state_t;

  localparam int CHAR_W = 8;

  // Printable ASCII range walked by the character counters.
  localparam logic [7:0] ASCII_MIN = 8'h20;
  localparam logic [7:0] ASCII_MAX = 8'h7E;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clr has priority over inc, count sticks at all-ones.
// Latency: count reflects clr/inc one cycle later; no handshake.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/password_matcher.sv
// Compares accepted candidates against a latched target and counts attempts.
// Results register on the transfer edge (1-cycle latency); cand_ready is high only while searching.
module password_matcher
  import pw_pkg::*;
#(
  parameter int N_CHARS = 4,
  parameter int CHAR_W  = pw_pkg::CHAR_W,
  parameter int CNT_W   = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [N_CHARS*CHAR_W-1:0]   target,
  input  logic                        cand_valid,
  input  logic [N_CHARS*CHAR_W-1:0]   cand_data,
  input  logic                        cand_last,
  output logic                        cand_ready,
  output logic                        busy,
  output logic                        found,
  output logic                        exhausted,
  output logic [N_CHARS*CHAR_W-1:0]   match_data,
  output logic [CNT_W-1:0]            attempts
);

  localparam int W = N_CHARS * CHAR_W;

  state_t         state;
  logic [W-1:0]   target_q;
  logic [W-1:0]   match_q;
  logic           xfer;
  logic           hit;
  logic           cnt_clr;
  logic           cnt_inc;

  assign cand_ready = (state == SEARCH);
  assign busy       = (state == SEARCH);
  assign found      = (state == FOUND);
  assign exhausted  = (state == EXHAUSTED);
  assign match_data = match_q;

  assign xfer = cand_valid && cand_ready;
  assign hit  = (cand_data == target_q);

  // A candidate arriving alongside start/abort is neither counted nor compared.
  assign cnt_clr = start && !abort;
  assign cnt_inc = xfer && !start && !abort;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_attempts (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (attempts)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      target_q <= '0;
      match_q  <= '0;
    end else if (abort) begin
      state <= IDLE;
      if (state != SEARCH) begin
        match_q <= '0;
      end
    end else if (start) begin
      state    <= SEARCH;
      target_q <= target;
      match_q  <= '0;
    end else if (xfer) begin
      // Match outranks cand_last when both land on the same transfer.
      if (hit) begin
        state   <= FOUND;
        match_q <= cand_data;
      end else if (cand_last) begin
        state <= EXHAUSTED;
      end
    end
  end

endmodule

// File: tb/tb_password_matcher.sv
// Directed table, hand-written corner sequences and a randomized reference-model run.
module tb_password_matcher;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  target = '0;
  logic          cand_valid = 1'b0;
  logic [W-1:0]  cand_data = '0;
  logic          cand_last = 1'b0;

  logic          cand_ready, busy, found, exhausted;
  logic [W-1:0]  match_data;
  logic [31:0]   attempts;

  logic          cand_ready3, busy3, found3, exhausted3;
  logic [W-1:0]  match_data3;
  logic [2:0]    attempts3;

  password_matcher #(.N_CHARS(4), .CHAR_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .target(target),
    .cand_valid(cand_valid), .cand_data(cand_data), .cand_last(cand_last),
    .cand_ready(cand_ready), .busy(busy), .found(found), .exhausted(exhausted),
    .match_data(match_data), .attempts(attempts)
  );

  password_matcher #(.N_CHARS(4), .CHAR_W(8), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .target(target),
    .cand_valid(cand_valid), .cand_data(cand_data), .cand_last(cand_last),
    .cand_ready(cand_ready3), .busy(busy3), .found(found3), .exhausted(exhausted3),
    .match_data(match_data3), .attempts(attempts3)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic ab, input logic v, input logic l,
                       input logic [W-1:0] tgt, input logic [W-1:0] d);
    start = st; abort = ab; cand_valid = v; cand_last = l; target = tgt; cand_data = d;
  endtask

  task automatic check_main(input string tag, input logic e_busy, input logic e_found,
                            input logic e_exh, input logic [31:0] e_att, input logic [W-1:0] e_match);
    chk({tag, ".busy"},       busy,       e_busy);
    chk({tag, ".cand_ready"}, cand_ready, e_busy);
    chk({tag, ".found"},      found,      e_found);
    chk({tag, ".exhausted"},  exhausted,  e_exh);
    chk({tag, ".attempts"},   attempts,   e_att);
    chk({tag, ".match_data"}, match_data, e_match);
  endtask

  typedef struct {
    logic        st, ab, v, l;
    logic [W-1:0] tgt, d;
    logic        e_busy, e_found, e_exh;
    logic [31:0] e_att;
    logic [W-1:0] e_match;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic ab, input logic v, input logic l,
                     input logic [W-1:0] tgt, input logic [W-1:0] d,
                     input logic eb, input logic ef, input logic ee,
                     input logic [31:0] ea, input logic [W-1:0] em);
    vec_t r;
    r.st = st; r.ab = ab; r.v = v; r.l = l; r.tgt = tgt; r.d = d;
    r.e_busy = eb; r.e_found = ef; r.e_exh = ee; r.e_att = ea; r.e_match = em;
    vecs.push_back(r);
  endtask

  // Reference model: search status as plain flags, attempts as an unbounded integer.
  bit          m_searching, m_found, m_exh;
  logic [W-1:0] m_target, m_match;
  longint      m_count;

  function automatic void model_reset();
    m_searching = 0; m_found = 0; m_exh = 0;
    m_target = '0; m_match = '0; m_count = 0;
  endfunction

  function automatic void model_step();
    if (abort) begin
      if (!m_searching) m_match = '0;
      m_searching = 0; m_found = 0; m_exh = 0;
    end else if (start) begin
      m_target = target; m_match = '0; m_count = 0;
      m_searching = 1; m_found = 0; m_exh = 0;
    end else if (m_searching && cand_valid) begin
      m_count++;
      if (cand_data == m_target) begin
        m_match = cand_data; m_searching = 0; m_found = 1;
      end else if (cand_last) begin
        m_searching = 0; m_exh = 1;
      end
    end
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < 4; i++) w[i*8 +: 8] = 8'h61 + 8'($urandom_range(0, 1));
    return w;
  endfunction

  initial begin
    logic [W-1:0] abcd, zzzz, aaaa, pass_w, qq, wxyz, newt, miss;
    longint sat;
    abcd = "abcd"; zzzz = "zzzz"; aaaa = "aaaa"; pass_w = "pass";
    qq = "qqqq"; wxyz = "wxyz"; newt = "newt"; miss = "mmmm";

    //       st ab v  l  tgt     data    busy fnd exh att match
    add(1, 0, 0, 0, abcd,  '0,     1, 0, 0, 0, '0);
    add(0, 0, 1, 0, '0,    aaaa,   1, 0, 0, 1, '0);
    add(0, 0, 1, 0, '0,    "abca", 1, 0, 0, 2, '0);
    add(0, 0, 1, 0, '0,    abcd,   0, 1, 0, 3, abcd);
    add(0, 0, 1, 0, '0,    aaaa,   0, 1, 0, 3, abcd);
    add(1, 0, 0, 0, zzzz,  '0,     1, 0, 0, 0, '0);
    add(0, 0, 1, 0, '0,    "zzza", 1, 0, 0, 1, '0);
    add(0, 0, 1, 0, '0,    "zzaz", 1, 0, 0, 2, '0);
    add(0, 0, 1, 0, '0,    "zazz", 1, 0, 0, 3, '0);
    add(0, 0, 1, 0, '0,    "azzz", 1, 0, 0, 4, '0);
    add(0, 0, 1, 1, '0,    aaaa,   0, 0, 1, 5, '0);
    add(0, 1, 0, 0, '0,    '0,     0, 0, 0, 5, '0);
    add(0, 0, 1, 0, '0,    aaaa,   0, 0, 0, 5, '0);
    add(1, 0, 0, 0, pass_w,'0,     1, 0, 0, 0, '0);
    add(0, 0, 1, 1, '0,    pass_w, 0, 1, 0, 1, pass_w);
    add(0, 1, 0, 0, '0,    '0,     0, 0, 0, 1, '0);
    add(1, 0, 0, 0, qq,    '0,     1, 0, 0, 0, '0);
    add(0, 0, 1, 0, '0,    miss,   1, 0, 0, 1, '0);
    add(0, 0, 0, 0, '0,    qq,     1, 0, 0, 1, '0);
    add(0, 0, 1, 0, '0,    miss,   1, 0, 0, 2, '0);
    add(1, 1, 1, 0, wxyz,  qq,     0, 0, 0, 2, '0);
    add(1, 0, 0, 0, wxyz,  '0,     1, 0, 0, 0, '0);

    // Reset state, held in reset with a valid candidate offered.
    cand_valid = 1'b1;
    #2;
    check_main("reset", 0, 0, 0, 0, '0);
    cyc();
    check_main("reset_clk", 0, 0, 0, 0, '0);
    rst_n = 1'b1;
    cand_valid = 1'b0;
    cyc();

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].ab, vecs[i].v, vecs[i].l, vecs[i].tgt, vecs[i].d);
      cyc();
      check_main($sformatf("vec%0d", i), vecs[i].e_busy, vecs[i].e_found,
                 vecs[i].e_exh, vecs[i].e_att, vecs[i].e_match);
    end

    // Restart after 10 attempts; candidate offered with start must be ignored.
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 0, '0, miss);
      cyc();
    end
    check_main("pre_restart", 1, 0, 0, 10, '0);
    drive(1, 0, 1, 0, newt, newt);
    cyc();
    check_main("restart", 1, 0, 0, 0, '0);
    drive(0, 0, 1, 0, '0, wxyz);
    cyc();
    check_main("old_target", 1, 0, 0, 1, '0);
    drive(0, 0, 1, 0, '0, newt);
    cyc();
    check_main("new_target", 0, 1, 0, 2, newt);

    // Saturation on the narrow-counter instance.
    drive(1, 0, 0, 0, zzzz, '0);
    cyc();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 0, '0, miss);
      cyc();
    end
    chk("sat.attempts32", attempts, 10);
    chk("sat.attempts3", attempts3, 7);
    chk("sat.busy3", busy3, 1);

    // Asynchronous reset mid-search: outputs clear before any clock edge.
    drive(0, 0, 1, 0, '0, miss);
    rst_n = 1'b0;
    #2;
    check_main("async_rst", 0, 0, 0, 0, '0);
    chk("async_rst.attempts3", attempts3, 0);
    cyc();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, '0, '0);
    model_reset();
    cyc();

    for (int i = 0; i < 2000; i++) begin
      start      = ($urandom_range(0, 19) == 0);
      abort      = ($urandom_range(0, 29) == 0);
      cand_valid = ($urandom_range(0, 9) < 7);
      cand_last  = ($urandom_range(0, 19) == 0);
      target     = rand_word();
      cand_data  = rand_word();
      model_step();
      cyc();
      sat = (m_count > 7) ? 7 : m_count;
      check_main($sformatf("rnd%0d", i), m_searching, m_found, m_exh,
                 32'(m_count), m_match);
      chk($sformatf("rnd%0d.attempts3", i), attempts3, 64'(sat));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/password_matcher.md
# password_matcher

Downstream consumer of the ASCII character counters in the brute-force datapath. It accepts one N-character candidate per cycle over a valid/ready handshake, compares it against a latched target password, and counts attempts. It reports either the matching candidate or exhaustion of the search space to the control/top level.

## Interface

- `N_CHARS`, default 4: characters per candidate.
- `CHAR_W`, default 8: bits per character (ASCII).
- `CNT_W`, default 32: attempt counter width.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle pulse: latch `target`, clear counters, begin search.
- `abort`  in  1  one-cycle pulse: stop the search and return to IDLE.
- `target`  in  N_CHARS*CHAR_W  password to find; sampled only when `start` is accepted. Char 0 is in the LSBs.
- `cand_valid`  in  1  upstream candidate valid.
- `cand_data`  in  N_CHARS*CHAR_W  candidate built from the counter `password` outputs; char 0 is in the LSBs.
- `cand_last`  in  1  final candidate of the space; driven from the most-significant counter `wrap`. Qualified by `cand_valid`.
- `cand_ready`  out  1  block accepts a candidate this cycle.
- `busy`  out  1  state is SEARCH.
- `found`  out  1  state is FOUND.
- `exhausted`  out  1  state is EXHAUSTED.
- `match_data`  out  N_CHARS*CHAR_W  candidate that matched; valid while `found`.
- `attempts`  out  CNT_W  number of candidates accepted since the last start.

## Operation

- States: IDLE, SEARCH, FOUND, EXHAUSTED.
- Transfer occurs when `cand_valid && cand_ready`. `cand_ready` = (state == SEARCH). It is a combinational function of state only, with no dependence on `cand_valid`.
- IDLE, FOUND, EXHAUSTED, on `start`: latch `target`, clear `attempts` and `match_data`, go to SEARCH.
- SEARCH, on transfer: increment `attempts`.
  - If `cand_data == target_q` (full-width equality), latch `match_data` and go to FOUND.
  - Otherwise, if `cand_last`, go to EXHAUSTED.
  - Otherwise stay in SEARCH.
- Match and `cand_last` on the same transfer: FOUND wins.
- SEARCH, on `start`: restart. Relatch the target, clear counters, stay in SEARCH. Any candidate presented that cycle is not counted or compared.
- SEARCH, on `abort`: go to IDLE. `attempts` holds its value.
- `abort` in any other state: go to IDLE. `match_data` is cleared.
- `start` and `abort` together: `abort` wins.
- `attempts` saturates at 2^CNT_W-1 and never wraps.
- Reset values: state IDLE, `target_q`=0, `match_data`=0, `attempts`=0. All status outputs and `cand_ready` are 0.
- Reset asserted mid-search: outputs return to their reset values immediately, without waiting for a clock edge.

## Timing

- Compare is combinational on the transfer cycle. All results are registered on that same edge.
- `found`/`exhausted` assert in the cycle after the matching or last transfer (1-cycle latency). `cand_ready` drops in that same cycle, so no extra candidate is accepted after a match.
- `attempts` reflects a transfer in the following cycle.
- `busy` and `cand_ready` rise in the cycle after `start`.
- Throughput: one candidate per cycle while `cand_valid` is held high.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.

## Structure

- Shared package `pw_pkg`:
  - `state_t` enum {IDLE, SEARCH, FOUND, EXHAUSTED}.
  - `CHAR_W` default.
  - Constants for the ASCII range bounds used by the counters, `ASCII_MIN`=8'h20 and `ASCII_MAX`=8'h7E.
- Sub-module `sat_counter` (parameter CNT_W; ports clr, inc, count): a saturating attempt counter that is reusable elsewhere in the datapath.
- The rest is a single FSM plus registers in `password_matcher`.

## Test plan

- Match: start with target "abcd". Feed "aaaa", "abca", "abcd" back-to-back. Required: `found`=1 one cycle after the third transfer, `match_data`="abcd", `attempts`=3, `cand_ready`=0 thereafter.
- Exhaustion: start with target "zzzz". Feed 5 non-matching candidates, the 5th with `cand_last`=1. Required: `exhausted`=1, `found`=0, `attempts`=5.
- Match on last: the matching candidate carries `cand_last`=1. Required: `found`=1, `exhausted`=0.
- Backpressure and idle: `cand_valid` toggles 1,0,1 while in SEARCH. Required: `attempts` counts only valid cycles. In IDLE with `cand_valid`=1, required: `cand_ready`=0 and `attempts` unchanged.
- Control: `start` mid-search, after 10 attempts, with a new target. Required: `attempts` back to 0 and the new target used. `start` plus `abort` together: IDLE. `abort` in FOUND: IDLE with `match_data`=0.
- Reset and saturation: assert `rst_n`=0 mid-search. Required: all outputs are 0 before the next clock edge. With CNT_W=3, feed 10 misses. Required: `attempts`=7.
